button_conditioner: RTL and testbench

//   Upstream front end for the user buttons of the DPWM design. It feeds the
//   3-bit frequency counter, the 10-bit current counter and the mode control.

---
 rtl/button_conditioner_if.sv | 19 +
 rtl/button_conditioner.sv | 97 +++++++++
 tb/tb_button_conditioner.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// button_conditioner_if: raw button inputs and conditioned command outputs
interface button_conditioner_if;
  logic       btn_up;
  logic       btn_down;
  logic       btn_sel;
  logic       up_pulse;
  logic       down_pulse;
  logic       sel_pulse;
  logic       sel_mode;
  logic [2:0] deb_state;
  modport master (
    output btn_up, btn_down, btn_sel,
    input  up_pulse, down_pulse, sel_pulse, sel_mode, deb_state
  );
  modport slave (
    input  btn_up, btn_down, btn_sel,
    output up_pulse, down_pulse, sel_pulse, sel_mode, deb_state
  );
endinterface

// File: rtl/button_conditioner.sv
// button_conditioner: sync, debounce and pulse/repeat generation for UP, DOWN and SEL buttons
module button_conditioner #(
  parameter int DEB_CYCLES   = 1_000_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int CNT_W        = 26
) (
  input logic clk,
  input logic reset,
  button_conditioner_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] FIRST  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] REPEAT = 2'd3;
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  logic [2:0] raw, s1, s2, deb, deb_q;
  logic [1:0] p_q;
  logic       both, sel_p, mode;
  assign raw  = {bus.btn_sel, bus.btn_down, bus.btn_up};
  assign both = deb[0] & deb[1];
  // two-flop synchronisers, the only consumers of the raw buttons
  always_ff @(posedge clk)
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  // previous debounced levels for rising-edge detection
  always_ff @(posedge clk)
    if (!reset) deb_q <= '0;
    else deb_q <= deb;
  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic             lvl;
    logic [CNT_W-1:0] cnt;
    assign deb[i] = lvl;
    // accept a level change only after DEB_CYCLES consecutive differing samples
    always_ff @(posedge clk)
      if (!reset) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (s2[i] == lvl) cnt <= '0;
      else if (cnt >= DEB_LAST) begin
        lvl <= s2[i];
        cnt <= '0;
      end else cnt <= cnt + ONE;
  end
  for (genvar i = 0; i < 2; i++) begin : g_rep
    logic [1:0]       st;
    logic [CNT_W-1:0] tmr;
    logic             p;
    assign p_q[i] = p;
    // press/hold FSM; tmr counts cycles since the last emitted pulse so the
    // first repeat lands exactly REPEAT_DELAY after the first pulse
    always_ff @(posedge clk)
      if (!reset || !deb[i] || both) begin
        st  <= IDLE;
        tmr <= '0;
        p   <= 1'b0;
      end else begin
        p   <= 1'b0;
        tmr <= (tmr == '1) ? tmr : tmr + ONE;
        if (st == IDLE && !deb_q[i]) begin
          st  <= FIRST;
          tmr <= '0;
          p   <= 1'b1;
        end else if (st == FIRST) st <= WAIT;
        else if (st == WAIT && tmr >= RD_LAST) begin
          st  <= REPEAT;
          tmr <= '0;
          p   <= 1'b1;
        end else if (st == REPEAT && tmr >= RR_LAST) begin
          tmr <= '0;
          p   <= 1'b1;
        end
      end
  end
  // SEL: one pulse per debounced press, mode flips on the edge after the pulse
  always_ff @(posedge clk)
    if (!reset) begin
      sel_p <= 1'b0;
      mode  <= 1'b0;
    end else begin
      sel_p <= deb[2] & ~deb_q[2];
      mode  <= mode ^ sel_p;
    end
  assign bus.up_pulse   = p_q[0] & ~both;
  assign bus.down_pulse = p_q[1] & ~both;
  assign bus.sel_pulse  = sel_p;
  assign bus.sel_mode   = mode;
  assign bus.deb_state  = deb;
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed checks of debounce latency, repeat timing, lockout, SEL and reset
module tb_button_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;
  int t = 0;
  int up_q[$], dn_q[$], sel_q[$];
  int deb_at[3];
  int mode_at_pulse;
  int exp3[9] = '{7, 27, 32, 37, 42, 47, 52, 57, 62};
  int exp5[3] = '{1, 0, 1};
  button_conditioner_if bus();
  button_conditioner #(
    .DEB_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_RATE(5), .CNT_W(26)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic clr();
    t = 0;
    up_q.delete();
    dn_q.delete();
    sel_q.delete();
    for (int b = 0; b < 3; b++) deb_at[b] = -1;
  endtask
  task automatic watch(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      t++;
      if (bus.up_pulse) up_q.push_back(t);
      if (bus.down_pulse) dn_q.push_back(t);
      if (bus.sel_pulse) begin
        sel_q.push_back(t);
        mode_at_pulse = int'(bus.sel_mode);
      end
      for (int b = 0; b < 3; b++) if (bus.deb_state[b] && deb_at[b] < 0) deb_at[b] = t;
    end
  endtask
  task automatic check_idle(input string tag);
    check({tag, "_up"}, int'(bus.up_pulse), 0);
    check({tag, "_down"}, int'(bus.down_pulse), 0);
    check({tag, "_sel"}, int'(bus.sel_pulse), 0);
    check({tag, "_mode"}, int'(bus.sel_mode), 0);
    check({tag, "_deb"}, int'(bus.deb_state), 0);
  endtask
  initial begin
    bus.btn_up = 1'b0;
    bus.btn_down = 1'b0;
    bus.btn_sel = 1'b0;
    clr();
    watch(3);
    check_idle("reset");
    reset = 1'b1;
    watch(5);
    // 1: three-cycle glitch is filtered
    clr();
    bus.btn_up = 1'b1;
    watch(3);
    bus.btn_up = 1'b0;
    watch(10);
    check("t1_pulses", up_q.size(), 0);
    check("t1_deb_at", deb_at[0], -1);
    // 2: single press, exact latency
    clr();
    bus.btn_up = 1'b1;
    watch(8);
    bus.btn_up = 1'b0;
    watch(12);
    check("t2_count", up_q.size(), 1);
    check("t2_first", (up_q.size() > 0) ? up_q[0] : -1, 7);
    check("t2_deb_at", deb_at[0], 6);
    check("t2_deb_end", int'(bus.deb_state), 0);
    // 3: hold-to-repeat on DOWN
    clr();
    bus.btn_down = 1'b1;
    watch(60);
    bus.btn_down = 1'b0;
    watch(20);
    check("t3_count", dn_q.size(), 9);
    for (int i = 0; i < 9; i++)
      check($sformatf("t3_pulse%0d", i), (i < dn_q.size()) ? dn_q[i] : -1, exp3[i]);
    check("t3_up", up_q.size(), 0);
    // 4: UP held, DOWN pressed -> lockout until UP re-pressed
    clr();
    bus.btn_up = 1'b1;
    watch(30);
    bus.btn_down = 1'b1;
    watch(20);
    bus.btn_down = 1'b0;
    watch(40);
    check("t4_up_count", up_q.size(), 3);
    check("t4_up_last", (up_q.size() > 0) ? up_q[up_q.size()-1] : -1, 32);
    check("t4_down_count", dn_q.size(), 0);
    check("t4_down_deb_at", deb_at[1], 36);
    bus.btn_up = 1'b0;
    watch(10);
    clr();
    bus.btn_up = 1'b1;
    watch(10);
    check("t4_repress_count", up_q.size(), 1);
    check("t4_repress_first", (up_q.size() > 0) ? up_q[0] : -1, 7);
    bus.btn_up = 1'b0;
    watch(10);
    // 5: three SEL presses
    for (int p = 0; p < 3; p++) begin
      clr();
      bus.btn_sel = 1'b1;
      watch(8);
      bus.btn_sel = 1'b0;
      watch(10);
      check($sformatf("t5_count%0d", p), sel_q.size(), 1);
      check($sformatf("t5_at%0d", p), (sel_q.size() > 0) ? sel_q[0] : -1, 7);
      check($sformatf("t5_mode_pulse%0d", p), mode_at_pulse, 1 - exp5[p]);
      check($sformatf("t5_mode%0d", p), int'(bus.sel_mode), exp5[p]);
      check($sformatf("t5_updown%0d", p), up_q.size() + dn_q.size(), 0);
    end
    // 6: reset during REPEAT, where a pulse would otherwise land
    clr();
    bus.btn_up = 1'b1;
    watch(36);
    check("t6_pre_count", up_q.size(), 3);
    reset = 1'b0;
    watch(1);
    reset = 1'b1;
    check_idle("t6_reset");
    clr();
    watch(10);
    check("t6_deb_at", deb_at[0], 6);
    check("t6_count", up_q.size(), 1);
    check("t6_first", (up_q.size() > 0) ? up_q[0] : -1, 7);
    bus.btn_up = 1'b0;
    watch(10);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
